wb_skid_stage: RTL and testbench
================================

Name: wb_skid_stage

Overview:
- 64-bit write-back pipeline stage with a valid/ready handshake and a two-entry skid buffer.
- Sits directly upstream of the 64-bit register file: it holds result data, destination register number and write flag, and presents them as the register file's write data/enable source.
- Absorbs one cycle of downstream back-pressure without combinational ready paths.
- Supports a synchronous pipeline flush.

Parameters:
- DATA_W, 64, width of result data.
- ADDR_W, 5, width of destination register number.
- ZERO_REG, 31, register number that is hard-wired zero; writes to it are suppressed.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous squash of all held entries.
- in_valid  input  1  upstream entry valid.
- in_ready  output  1  stage can accept an entry this cycle.
- in_data  input  DATA_W  result value.
- in_dest  input  ADDR_W  destination register number.
- in_wr_en  input  1  entry writes the register file.
- out_valid  output  1  output entry valid.
- out_ready  input  1  register-file side consumes the entry this cycle.
- out_data  output  DATA_W  result value to register file.
- out_dest  output  ADDR_W  destination register number.
- out_wr_en  output  1  write enable to register file; qualified by out_valid.

Interface (already decided):
- One clock, clk.
- Reset is synchronous and active-high, named reset.

Behaviour:
- Storage:
  - main slot drives the out_* ports directly from registers.
  - skid slot holds an overflow entry.
- Handshakes:
  - Accept occurs when in_valid && in_ready.
  - Drain occurs when out_valid && out_ready.
  - in_ready is a register: 1 iff the skid slot is empty. It never depends combinationally on out_ready.
- State encoding: EMPTY (no entries), ONE (main valid), FULL (main and skid valid).
- Transitions:
  - EMPTY: accept -> ONE, main <= in. Otherwise hold.
  - ONE: accept and drain -> ONE, main <= in. Accept only -> FULL, skid <= in. Drain only -> EMPTY. Neither -> hold.
  - FULL: in_ready = 0, so no accept. Drain -> ONE, main <= skid. No drain -> hold with all outputs stable.
- Ordering: strict FIFO. Entries leave in acceptance order; none is duplicated or dropped, except by flush.
- Latency: an entry accepted at edge N is visible on out_* after edge N, i.e. one cycle.
- Stability: while out_valid && !out_ready, out_data, out_dest and out_wr_en hold unchanged.
- Zero-register rule: an entry with in_dest == ZERO_REG is stored with wr_en = 0. Data and dest are kept as given.
- out_wr_en is 0 whenever out_valid is 0.
- flush:
  - Next state is EMPTY and in_ready is 1.
  - An input offered in the same cycle is dropped.
  - A drain in the same cycle still counts as consumed by downstream.
  - Data registers may hold stale values but out_wr_en must be 0.
- reset:
  - Has priority over flush.
  - Effective from any state, including mid-stall.
  - Reset values: out_valid = 0, in_ready = 1, out_data = 0, out_dest = 0, out_wr_en = 0; skid contents = 0.
- Data path is pass-through: no arithmetic and no width conversion.

Optional Feature:
- Macro: WB_SKID_STALL_CNT_EN.
- When defined:
  - Adds output port stall_cnt, 32 bits.
  - Counts cycles with out_valid && !out_ready.
  - Saturates at 32'hFFFFFFFF.
  - Cleared by reset; unaffected by flush.
- When not defined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then in_valid = 1, in_data = 64'hDEADBEEF_00000001, dest = 3, wr_en = 1, out_ready = 1 -> one cycle later out_valid = 1, out_data = 64'hDEADBEEF_00000001, out_dest = 3, out_wr_en = 1.
- Stream 10 back-to-back entries (data = 1..10) with out_ready = 1 -> 10 outputs in order, one per cycle; in_ready stays 1.
- Hold out_ready = 0 and offer data 5, 6, 7 -> 5 held on out, 6 in skid, in_ready = 0, 7 not accepted. Raise out_ready -> outputs 5, 6, then 7 once re-offered.
- Entry with dest = 31, wr_en = 1, data = 64'hFF -> out_valid = 1, out_dest = 31, out_wr_en = 0.
- FULL state, then assert flush together with in_valid (data = 9) -> next cycle out_valid = 0, in_ready = 1; data 9 never appears.
- With WB_SKID_STALL_CNT_EN: 4 stall cycles, then reset mid-stall -> stall_cnt = 4 before reset; after reset stall_cnt = 0, out_valid = 0, out_data = 0.

Source files
------------

// File: rtl/wb_skid_stage.sv
// Write-back stage with a two-entry skid buffer feeding the register file write port.
// Optional saturating stall counter enabled by defining WB_SKID_STALL_CNT_EN.
module wb_skid_stage #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_dest,
  input  logic              in_wr_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_dest,
  output logic              out_wr_en
`ifdef WB_SKID_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e            state_q, state_d;
  logic              in_ready_q, out_valid_q;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [ADDR_W-1:0] main_dest_q, main_dest_d, skid_dest_q, skid_dest_d;
  logic              main_wr_q, main_wr_d, skid_wr_q, skid_wr_d;
  logic              accept, drain, in_wr_eff;

  assign accept    = in_valid && in_ready_q;
  assign drain     = out_valid_q && out_ready;
  assign in_wr_eff = in_wr_en && (in_dest != ADDR_W'(ZERO_REG));

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_dest_d = main_dest_q;
    main_wr_d   = main_wr_q;
    skid_data_d = skid_data_q;
    skid_dest_d = skid_dest_q;
    skid_wr_d   = skid_wr_q;
    case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d     = StOne;
          main_data_d = in_data;
          main_dest_d = in_dest;
          main_wr_d   = in_wr_eff;
        end
      end
      StOne: begin
        if (accept && drain) begin
          main_data_d = in_data;
          main_dest_d = in_dest;
          main_wr_d   = in_wr_eff;
        end else if (accept) begin
          state_d     = StFull;
          skid_data_d = in_data;
          skid_dest_d = in_dest;
          skid_wr_d   = in_wr_eff;
        end else if (drain) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (drain) begin
          state_d     = StOne;
          main_data_d = skid_data_q;
          main_dest_d = skid_dest_q;
          main_wr_d   = skid_wr_q;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Squash wins over everything except reset; stale data is harmless once wr is cleared.
    if (flush) begin
      state_d   = StEmpty;
      main_wr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StEmpty;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_data_q <= '0;
      main_dest_q <= '0;
      main_wr_q   <= 1'b0;
      skid_data_q <= '0;
      skid_dest_q <= '0;
      skid_wr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != StFull);
      out_valid_q <= (state_d != StEmpty);
      main_data_q <= main_data_d;
      main_dest_q <= main_dest_d;
      main_wr_q   <= main_wr_d;
      skid_data_q <= skid_data_d;
      skid_dest_q <= skid_dest_d;
      skid_wr_q   <= skid_wr_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_data_q;
  assign out_dest  = main_dest_q;
  assign out_wr_en = out_valid_q & main_wr_q;

`ifdef WB_SKID_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (out_valid_q && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_wb_skid_stage.sv
// Bench for wb_skid_stage: directed steps plus random traffic checked against a queue model.
module tb_wb_skid_stage;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 5;
  localparam int unsigned ZR = 31;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready, in_wr_en;
  logic          out_valid, out_ready, out_wr_en;
  logic [DW-1:0] in_data, out_data;
  logic [AW-1:0] in_dest, out_dest;
`ifdef WB_SKID_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  always #5 clk = ~clk;

  wb_skid_stage #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .ZERO_REG (ZR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .in_wr_en  (in_wr_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_dest  (out_dest),
    .out_wr_en (out_wr_en)
`ifdef WB_SKID_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    logic          w;
  } ent_t;

  ent_t        q[$];       // entries held by the stage, oldest first, capacity two
  logic [31:0] m_stall;
  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [AW-1:0] a,
                       input logic w, input logic r);
    in_valid  = v;
    in_data   = d;
    in_dest   = a;
    in_wr_en  = w;
    out_ready = r;
  endtask

  // Check outputs against the model, advance the model by the current inputs, clock once.
  task automatic cyc();
    ent_t e;
    logic drn, acc;
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    if (q.size() > 0) begin
      chk("out_data", out_data, q[0].d);
      chk("out_dest", 64'(out_dest), 64'(q[0].a));
      chk("out_wr_en", 64'(out_wr_en), 64'(q[0].w));
    end else begin
      chk("idle_wr_en", 64'(out_wr_en), 64'd0);
    end
`ifdef WB_SKID_STALL_CNT_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
    if (reset) begin
      q.delete();
      m_stall = '0;
    end else begin
      if (q.size() > 0 && !out_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
      drn = (q.size() > 0) && out_ready;
      acc = in_valid && (q.size() < 2) && !flush;
      e   = '{d: in_data, a: in_dest, w: in_wr_en && (in_dest != AW'(ZR))};
      if (flush) begin
        q.delete();
      end else begin
        if (drn) void'(q.pop_front());
        if (acc) q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_dest", 64'(out_dest), 64'd0);
    chk("rst_out_wr_en", 64'(out_wr_en), 64'd0);
    q.delete();
    m_stall = '0;
    reset   = 1'b0;

    // Single entry, one-cycle latency.
    drive(1'b1, 64'hDEADBEEF_00000001, 5'd3, 1'b1, 1'b1);
    cyc();
    in_valid = 1'b0;
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_data", out_data, 64'hDEADBEEF_00000001);
    chk("t1_dest", 64'(out_dest), 64'd3);
    chk("t1_wr_en", 64'(out_wr_en), 64'd1);
    cyc();

    // Back-to-back stream.
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 64'(i), 5'(i), 1'b1, 1'b1);
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    cyc();

    // Back-pressure: 5 in main, 6 in skid, 7 refused.
    drive(1'b1, 64'd5, 5'd5, 1'b1, 1'b0);
    cyc();
    in_data = 64'd6;
    cyc();
    in_data = 64'd7;
    cyc();
    chk("bp_main", out_data, 64'd5);
    chk("bp_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    cyc();
    chk("bp_second", out_data, 64'd6);
    cyc();
    chk("bp_third", out_data, 64'd7);
    in_valid = 1'b0;
    cyc();
    cyc();

    // Zero register suppresses the write.
    drive(1'b1, 64'hFF, 5'd31, 1'b1, 1'b1);
    cyc();
    in_valid = 1'b0;
    chk("zr_valid", 64'(out_valid), 64'd1);
    chk("zr_dest", 64'(out_dest), 64'd31);
    chk("zr_wr_en", 64'(out_wr_en), 64'd0);
    cyc();

    // Flush from FULL with a concurrent offer.
    drive(1'b1, 64'd11, 5'd1, 1'b1, 1'b0);
    cyc();
    in_data = 64'd12;
    cyc();
    flush = 1'b1;
    in_data = 64'd9;
    cyc();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_ready", 64'(in_ready), 64'd1);
    chk("fl_wr_en", 64'(out_wr_en), 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cyc();

    // Four stall cycles, then reset mid-stall.
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    drive(1'b1, 64'h44, 5'd4, 1'b1, 1'b0);
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
`ifdef WB_SKID_STALL_CNT_EN
    chk("st_before", 64'(stall_cnt), 64'd4);
`endif
    reset = 1'b1;
    cyc();
    reset = 1'b0;
`ifdef WB_SKID_STALL_CNT_EN
    chk("st_after", 64'(stall_cnt), 64'd0);
`endif
    chk("st_valid", 64'(out_valid), 64'd0);
    chk("st_data", out_data, 64'd0);
    chk("st_ready", 64'(in_ready), 64'd1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, {$urandom, $urandom}, 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      flush = ($urandom_range(0, 19) == 0);
      reset = ($urandom_range(0, 99) == 0);
      cyc();
    end
    reset = 1'b0;
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    cyc();
    cyc();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
